// File: rtl/intr_pkg.sv
// Shared types and defaults for the interrupt controller slice.
package intr_pkg;

   localparam int unsigned NUM_SRC_DEF = 8;
   localparam int unsigned VEC_W_DEF   = 3;

   // Controller handshake phases.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      SVC  = 2'd2
   } state_e;

endpackage

// File: rtl/intr_priority_enc.sv
// Lowest-index-first priority encoder: source 0 has the highest priority.
module intr_priority_enc
   import intr_pkg::*;
#(
   parameter int unsigned NUM_SRC = NUM_SRC_DEF,
   parameter int unsigned VEC_W   = VEC_W_DEF
) (
   input  logic [NUM_SRC-1:0] req,
   output logic [VEC_W-1:0]   winner,
   output logic               any
);

   // Scan from the top down so the lowest set index is the last one written.
   always_comb begin
      winner = '0;
      any    = 1'b0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (req[i]) begin
            winner = VEC_W'(i);
            any    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/intr_controller.sv
// Prioritised, maskable interrupt controller with an in-service phase closed by EOI.
module intr_controller
   import intr_pkg::*;
#(
   parameter int unsigned        NUM_SRC    = NUM_SRC_DEF,
   parameter int unsigned        VEC_W      = VEC_W_DEF,
   parameter logic [NUM_SRC-1:0] EDGE_MASK  = '1,
   parameter logic [NUM_SRC-1:0] MASK_RESET = '0
) (
   input  logic               clk,
   input  logic               clr,
   input  logic [NUM_SRC-1:0] irq,
   input  logic               cfg_we,
   input  logic [NUM_SRC-1:0] cfg_data,
   output logic               intr,
   input  logic               inta,
   input  logic               eoi,
   output logic [VEC_W-1:0]   vector,
   output logic               in_service,
   output logic [NUM_SRC-1:0] mask,
   output logic [NUM_SRC-1:0] pending
);

   state_e               state_q, state_d;
   logic [VEC_W-1:0]     vector_q, vector_d;
   logic                 intr_q, intr_d;
   logic                 insvc_q, insvc_d;
   // One-cycle holdoff after EOI so the next request rises two edges after EOI.
   logic                 settle_q, settle_d;
   logic                 ack;
   logic [NUM_SRC-1:0]   irq_q;
   logic [NUM_SRC-1:0]   mask_q, mask_d;
   logic [NUM_SRC-1:0]   pend_q, pend_d;
   logic [NUM_SRC-1:0]   cand;
   logic [NUM_SRC-1:0]   ack_clr;
   logic [VEC_W-1:0]     winner;
   logic                 any;

   assign cand = pend_q & mask_q;

   intr_priority_enc #(
      .NUM_SRC (NUM_SRC),
      .VEC_W   (VEC_W)
   ) u_prio (
      .req    (cand),
      .winner (winner),
      .any    (any)
   );

   // Handshake FSM: arbitrate in IDLE, hold the request in REQ, hold the vector in SVC.
   always_comb begin
      state_d  = state_q;
      vector_d = vector_q;
      intr_d   = intr_q;
      insvc_d  = insvc_q;
      settle_d = 1'b0;
      ack      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (any && !settle_q) begin
               vector_d = winner;
               intr_d   = 1'b1;
               state_d  = REQ;
            end
         end
         REQ: begin
            if (inta) begin
               intr_d  = 1'b0;
               insvc_d = 1'b1;
               ack     = 1'b1;
               state_d = SVC;
            end
         end
         SVC: begin
            if (eoi) begin
               insvc_d  = 1'b0;
               settle_d = 1'b1;
               state_d  = IDLE;
            end
         end
         default: begin
            intr_d  = 1'b0;
            insvc_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // Acknowledge clears only the serviced source, and only if it is edge-triggered.
   always_comb begin
      ack_clr = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         ack_clr[i] = ack & EDGE_MASK[i] & (vector_q == VEC_W'(i));
      end
   end

   // Pending next state: edge sources latch rises (set beats clear), level sources follow irq.
   always_comb begin
      pend_d = pend_q;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (EDGE_MASK[i]) begin
            pend_d[i] = (irq[i] & ~irq_q[i]) | (pend_q[i] & ~ack_clr[i]);
         end else begin
            pend_d[i] = irq[i];
         end
      end
   end

   // Mask register next state; masking never touches pending.
   always_comb begin
      mask_d = mask_q;
      if (cfg_we) begin
         mask_d = cfg_data;
      end
   end

   // FSM state and handshake outputs.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q  <= IDLE;
         vector_q <= '0;
         intr_q   <= 1'b0;
         insvc_q  <= 1'b0;
         settle_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         vector_q <= vector_d;
         intr_q   <= intr_d;
         insvc_q  <= insvc_d;
         settle_q <= settle_d;
      end
   end

   // Source history, pending and mask registers.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         irq_q  <= '0;
         pend_q <= '0;
         mask_q <= MASK_RESET;
      end else begin
         irq_q  <= irq;
         pend_q <= pend_d;
         mask_q <= mask_d;
      end
   end

   assign intr       = intr_q;
   assign vector     = vector_q;
   assign in_service = insvc_q;
   assign mask       = mask_q;
   assign pending    = pend_q;

endmodule

// File: tb/tb_intr_controller.sv
// Scoreboard bench for intr_controller: source 0 level-triggered, sources 1..7 edge-triggered.
module tb_intr_controller;

   localparam int unsigned NS    = 8;
   localparam int unsigned VW    = 3;
   localparam logic [7:0]  EDGES = 8'hFE;
   localparam logic [7:0]  MRST  = 8'h00;
   localparam int PH_IDLE = 0;
   localparam int PH_REQ  = 1;
   localparam int PH_SVC  = 2;

   logic       clk = 1'b0;
   logic       clr;
   logic [7:0] irq;
   logic       cfg_we;
   logic [7:0] cfg_data;
   logic       intr;
   logic       inta;
   logic       eoi;
   logic [2:0] vector;
   logic       in_service;
   logic [7:0] mask;
   logic [7:0] pending;

   intr_controller #(
      .NUM_SRC    (NS),
      .VEC_W      (VW),
      .EDGE_MASK  (EDGES),
      .MASK_RESET (MRST)
   ) dut (
      .clk        (clk),
      .clr        (clr),
      .irq        (irq),
      .cfg_we     (cfg_we),
      .cfg_data   (cfg_data),
      .intr       (intr),
      .inta       (inta),
      .eoi        (eoi),
      .vector     (vector),
      .in_service (in_service),
      .mask       (mask),
      .pending    (pending)
   );

   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   typedef struct {
      int cyc;
      int vec;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference model state.
   logic [7:0] m_pend;
   logic [7:0] m_mask;
   logic [7:0] m_prev;
   int         m_phase;
   int         m_vec;
   logic       m_intr;
   logic       m_insvc;
   logic       m_settle;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int lowest(input logic [7:0] v);
      for (int i = 0; i < 8; i++) begin
         if (v[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_pend   = '0;
      m_mask   = MRST;
      m_prev   = '0;
      m_phase  = PH_IDLE;
      m_vec    = 0;
      m_intr   = 1'b0;
      m_insvc  = 1'b0;
      m_settle = 1'b0;
      exp_q.delete();
   endtask

   // Advance the model by one clock edge given the inputs present before that edge.
   task automatic model_step(input logic [7:0] i_irq, input logic we, input logic [7:0] d,
                             input logic a, input logic e);
      logic [7:0] cand;
      logic       acked;
      int         acked_src;
      exp_t       x;
      cand      = m_pend & m_mask;
      acked     = 1'b0;
      acked_src = m_vec;
      if (m_phase == PH_IDLE) begin
         if (m_settle) begin
            m_settle = 1'b0;
         end else if (cand != 0) begin
            m_vec   = lowest(cand);
            m_intr  = 1'b1;
            m_phase = PH_REQ;
            x.cyc   = edge_cnt;
            x.vec   = m_vec;
            exp_q.push_back(x);
         end
      end else if (m_phase == PH_REQ) begin
         if (a) begin
            m_intr  = 1'b0;
            m_insvc = 1'b1;
            acked   = 1'b1;
            m_phase = PH_SVC;
         end
      end else begin
         if (e) begin
            m_insvc  = 1'b0;
            m_settle = 1'b1;
            m_phase  = PH_IDLE;
         end
      end
      for (int i = 0; i < 8; i++) begin
         if (EDGES[i]) begin
            if (i_irq[i] && !m_prev[i]) m_pend[i] = 1'b1;
            else if (acked && i == acked_src) m_pend[i] = 1'b0;
         end else begin
            m_pend[i] = i_irq[i];
         end
      end
      m_prev = i_irq;
      if (we) m_mask = d;
   endtask

   // Drive one cycle of inputs, step the model, and compare the visible registers.
   task automatic tick(input logic [7:0] i_irq, input logic we, input logic [7:0] d,
                       input logic a, input logic e);
      irq      = i_irq;
      cfg_we   = we;
      cfg_data = d;
      inta     = a;
      eoi      = e;
      @(posedge clk);
      #1;
      model_step(i_irq, we, d, a, e);
      chk("pending", 32'(pending), 32'(m_pend));
      chk("mask", 32'(mask), 32'(m_mask));
      chk("in_service", 32'(in_service), 32'(m_insvc));
      chk("intr_level", 32'(intr), 32'(m_intr));
      chk("vector", 32'(vector), 32'(m_vec));
      @(negedge clk);
   endtask

   task automatic wait_intr(input logic [7:0] hold);
      int budget;
      budget = 20;
      while (!intr && budget > 0) begin
         tick(hold, 1'b0, 8'h00, 1'b0, 1'b0);
         budget--;
      end
      chk("wait_intr", 32'(intr), 32'd1);
   endtask

   task automatic service(input logic [7:0] wait_irq, input logic [7:0] svc_irq, input int gap);
      wait_intr(wait_irq);
      tick(svc_irq, 1'b0, 8'h00, 1'b1, 1'b0);
      repeat (gap) tick(svc_irq, 1'b0, 8'h00, 1'b0, 1'b0);
      tick(svc_irq, 1'b0, 8'h00, 1'b0, 1'b1);
   endtask

   task automatic idle(input int n);
      repeat (n) tick(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   // Monitor: every intr rise must match the next predicted request in vector and edge.
   initial begin : monitor
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (intr === 1'b1 && !prev) begin
            if (exp_q.size() == 0) begin
               chk("intr_spurious", 32'(vector), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               chk("sb_vector", 32'(vector), 32'(e.vec));
               chk("sb_cycle", 32'(edge_cnt), 32'(e.cyc));
            end
         end
         prev = (intr === 1'b1);
      end
   end

   logic [7:0] r_irq;
   logic [7:0] r_data;
   logic       r_we;
   logic       r_a;
   logic       r_e;
   logic       lvl;
   int         lvl_cnt;

   initial begin : stim
      clr      = 1'b1;
      irq      = '0;
      cfg_we   = 1'b0;
      cfg_data = '0;
      inta     = 1'b0;
      eoi      = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_intr", 32'(intr), 32'd0);
      chk("rst_vector", 32'(vector), 32'd0);
      chk("rst_in_service", 32'(in_service), 32'd0);
      chk("rst_mask", 32'(mask), 32'(MRST));
      chk("rst_pending", 32'(pending), 32'd0);
      @(negedge clk);
      clr = 1'b0;

      // Single edge source 3; stray eoi and inta in IDLE first.
      tick(8'h00, 1'b1, 8'h08, 1'b0, 1'b1);
      tick(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
      tick(8'h08, 1'b0, 8'h00, 1'b0, 1'b0);
      service(8'h00, 8'h00, 2);
      idle(6);

      // Simultaneous requests 2 and 5.
      tick(8'h00, 1'b1, 8'hFF, 1'b0, 1'b0);
      tick(8'h24, 1'b0, 8'h00, 1'b0, 1'b0);
      service(8'h00, 8'h00, 1);
      service(8'h00, 8'h00, 1);
      idle(4);

      // Masked source 1 stays pending until enabled.
      tick(8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
      tick(8'h02, 1'b0, 8'h00, 1'b0, 1'b0);
      idle(4);
      tick(8'h00, 1'b1, 8'h02, 1'b0, 1'b0);
      service(8'h00, 8'h00, 1);
      idle(4);

      // Level source 0 re-requests after EOI while held, then stops once dropped.
      tick(8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
      service(8'h01, 8'h01, 2);
      service(8'h01, 8'h00, 2);
      idle(6);

      // Edge on source 4 during its own service, plus a stray inta in SVC.
      tick(8'h00, 1'b1, 8'h10, 1'b0, 1'b0);
      tick(8'h10, 1'b0, 8'h00, 1'b0, 1'b0);
      wait_intr(8'h00);
      tick(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
      tick(8'h10, 1'b0, 8'h00, 1'b0, 1'b0);
      tick(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
      tick(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
      idle(2);
      tick(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
      service(8'h00, 8'h00, 1);
      idle(4);

      // Asynchronous reset with a request outstanding.
      tick(8'h00, 1'b1, 8'hFF, 1'b0, 1'b0);
      tick(8'h40, 1'b0, 8'h00, 1'b0, 1'b0);
      wait_intr(8'h00);
      #2;
      clr = 1'b1;
      #1;
      chk("arst_intr", 32'(intr), 32'd0);
      chk("arst_vector", 32'(vector), 32'd0);
      chk("arst_pending", 32'(pending), 32'd0);
      chk("arst_mask", 32'(mask), 32'(MRST));
      chk("arst_in_service", 32'(in_service), 32'd0);
      model_reset();
      @(negedge clk);
      clr = 1'b0;

      // Randomised traffic with a reactive CPU and occasional stray handshakes.
      lvl     = 1'b0;
      lvl_cnt = 4;
      for (int n = 0; n < 400; n++) begin
         r_irq = '0;
         for (int b = 1; b < 8; b++) begin
            if ($urandom_range(0, 5) == 0) r_irq[b] = 1'b1;
         end
         if (lvl_cnt == 0) begin
            lvl     = ~lvl;
            lvl_cnt = $urandom_range(3, 15);
         end else begin
            lvl_cnt--;
         end
         r_irq[0] = lvl;
         r_we     = ($urandom_range(0, 19) == 0);
         r_data   = 8'($urandom);
         r_a      = intr ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 29) == 0);
         r_e      = in_service ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0);
         tick(r_irq, r_we, r_data, r_a, r_e);
      end

      // Drain: quiet sources, CPU answers every handshake.
      for (int n = 0; n < 60; n++) begin
         tick(8'h00, 1'b0, 8'h00, intr, in_service);
      end
      chk("sb_drain", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
